// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//   EX-stage branch resolution. Computes the real next PC of a conditional
//   branch / JAL / JALR, compares it with the PC predicted at fetch, and
//   drives the pipeline flush, the PC redirect, the predictor update port and
//   two saturating performance counters.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   ex_valid            ID/EX holds a live instruction
//   is_stall            EX instruction does not resolve this cycle
//   is_branch/jal/jalr  control-flow kind of the EX instruction
//   bcond               ALU branch condition
//   ex_pc, ex_predicted_pc, ex_imm, ex_rs1   EX operands
//   actual_pc           resolved next PC (combinational)
//   mispredict          resolved this cycle with a wrong prediction
//   flush_if_id/id_ex   squash the younger pipeline registers at next edge
//   redirect_valid/pc   registered PC redirect (one-cycle pulse, pc holds)
//   upd_valid/pc/target/taken  registered predictor update (pulse, data holds)
//   branch_count        resolved control-flow instructions (saturating)
//   mispredict_count    mispredictions (saturating)
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             is_stall,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic             bcond,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_predicted_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rs1,
  output logic [XLEN-1:0]  actual_pc,
  output logic             mispredict,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             upd_valid,
  output logic [XLEN-1:0]  upd_pc,
  output logic [XLEN-1:0]  upd_target,
  output logic             upd_taken,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  // JALR clears bit 0 of its computed target.
  localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  logic [0:0]       r_state;
  logic             r_redirect_valid;
  logic [XLEN-1:0]  r_redirect_pc;
  logic             r_upd_valid;
  logic [XLEN-1:0]  r_upd_pc;
  logic [XLEN-1:0]  r_upd_target;
  logic             r_upd_taken;
  logic [CNT_W-1:0] r_branch_count;
  logic [CNT_W-1:0] r_mispredict_count;

  logic             w_is_ctl;
  logic             w_taken;
  logic [XLEN-1:0]  w_pc_rel;
  logic [XLEN-1:0]  w_jalr_tgt;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_seq_pc;
  logic [XLEN-1:0]  w_actual_pc;
  logic             w_resolve;
  logic             w_mispredict;
  logic             w_flush;
  logic             w_branch_sat;
  logic             w_mispred_sat;

  // -------------------------------------------------------------------------
  // Target / next-PC computation (all sums wrap mod 2^XLEN)
  // -------------------------------------------------------------------------
  assign w_is_ctl   = is_branch | is_jal | is_jalr;
  assign w_taken    = is_jal | is_jalr | (is_branch & bcond);
  assign w_pc_rel   = ex_pc + ex_imm;
  assign w_jalr_tgt = (ex_rs1 + ex_imm) & JALR_MASK;
  assign w_target   = is_jalr ? w_jalr_tgt : w_pc_rel;
  assign w_seq_pc   = ex_pc + XLEN'(4);
  assign w_actual_pc = w_taken ? w_target : w_seq_pc;

  // The instruction in EX during FLUSH is wrong-path, so only IDLE resolves.
  // Reset masks the combinational strobes so nothing leaks out in that cycle.
  assign w_resolve    = ~reset & ex_valid & w_is_ctl & ~is_stall & (r_state == S_IDLE);
  assign w_mispredict = w_resolve & (w_actual_pc != ex_predicted_pc);
  // Cycle T kills the two wrong-path instructions already in IF/ID and ID/EX;
  // T+1 (FLUSH) kills the one fetched during T before the redirect lands.
  assign w_flush      = ~reset & (w_mispredict | (r_state == S_FLUSH));

  assign w_branch_sat  = &r_branch_count;
  assign w_mispred_sat = &r_mispredict_count;

  // -------------------------------------------------------------------------
  // Flush FSM: one extra flush cycle after every mispredict
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= w_mispredict ? S_FLUSH : S_IDLE;
        S_FLUSH: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Redirect: valid pulses for one cycle, target holds afterwards
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= w_mispredict;
      if (w_mispredict) r_redirect_pc <= w_actual_pc;
    end
  end

  // -------------------------------------------------------------------------
  // Predictor update: every resolve trains the predictor, hit or miss
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_upd_valid  <= 1'b0;
      r_upd_pc     <= '0;
      r_upd_target <= '0;
      r_upd_taken  <= 1'b0;
    end else begin
      r_upd_valid <= w_resolve;
      if (w_resolve) begin
        r_upd_pc     <= ex_pc;
        r_upd_target <= w_actual_pc;
        r_upd_taken  <= w_taken;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Saturating performance counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_resolve && !w_branch_sat)     r_branch_count     <= r_branch_count + 1'b1;
      if (w_mispredict && !w_mispred_sat) r_mispredict_count <= r_mispredict_count + 1'b1;
    end
  end

  assign actual_pc        = w_actual_pc;
  assign mispredict       = w_mispredict;
  assign flush_if_id      = w_flush;
  assign flush_id_ex      = w_flush;
  assign redirect_valid   = r_redirect_valid;
  assign redirect_pc      = r_redirect_pc;
  assign upd_valid        = r_upd_valid;
  assign upd_pc           = r_upd_pc;
  assign upd_target       = r_upd_target;
  assign upd_taken        = r_upd_taken;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, is_stall, is_branch, is_jal, is_jalr, bcond;
  logic [31:0] ex_pc, ex_predicted_pc, ex_imm, ex_rs1;

  logic [31:0] actual_pc, redirect_pc, upd_pc, upd_target;
  logic        mispredict, flush_if_id, flush_id_ex, redirect_valid, upd_valid, upd_taken;
  logic [31:0] branch_count, mispredict_count;

  // narrow-counter instance shares the stimulus; only its counters are checked
  logic [31:0] s_actual_pc, s_redirect_pc, s_upd_pc, s_upd_target;
  logic        s_mispredict, s_flush_if_id, s_flush_id_ex, s_redirect_valid, s_upd_valid, s_upd_taken;
  logic [3:0]  s_branch_count, s_mispredict_count;

  int n_chk = 0;
  int n_pass = 0;

  // model state
  bit          m_in_flush;
  bit          m_rv, m_uv, m_utk;
  logic [31:0] m_rpc, m_upc, m_utg;
  int          m_bc, m_mc;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .is_stall(is_stall),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .bcond(bcond),
    .ex_pc(ex_pc), .ex_predicted_pc(ex_predicted_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .actual_pc(actual_pc), .mispredict(mispredict), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .branch_count(branch_count), .mispredict_count(mispredict_count));

  branch_resolve_unit #(.XLEN(32), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .is_stall(is_stall),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .bcond(bcond),
    .ex_pc(ex_pc), .ex_predicted_pc(ex_predicted_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .actual_pc(s_actual_pc), .mispredict(s_mispredict), .flush_if_id(s_flush_if_id),
    .flush_id_ex(s_flush_id_ex), .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .upd_valid(s_upd_valid), .upd_pc(s_upd_pc), .upd_target(s_upd_target), .upd_taken(s_upd_taken),
    .branch_count(s_branch_count), .mispredict_count(s_mispredict_count));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // ---- spec-level model ----
  function automatic logic [31:0] f_next_pc();
    logic tk;
    logic [31:0] tgt;
    tk  = is_jal | is_jalr | (is_branch & bcond);
    tgt = is_jalr ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
    return tk ? tgt : ex_pc + 32'd4;
  endfunction

  function automatic bit f_resolves();
    return !reset && ex_valid && (is_branch || is_jal || is_jalr) && !is_stall && !m_in_flush;
  endfunction

  function automatic int f_sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // compare every cycle at the falling edge
  task automatic chk();
    bit res, mp;
    @(negedge clk);
    res = f_resolves();
    mp  = res && (f_next_pc() != ex_predicted_pc);
    check("actual_pc",  actual_pc, f_next_pc());
    check("mispredict", mispredict, mp);
    check("flush_if_id", flush_if_id, !reset && (mp || m_in_flush));
    check("flush_id_ex", flush_id_ex, !reset && (mp || m_in_flush));
    check("redirect_valid", redirect_valid, m_rv);
    check("redirect_pc", redirect_pc, m_rpc);
    check("upd_valid", upd_valid, m_uv);
    check("upd_pc", upd_pc, m_upc);
    check("upd_target", upd_target, m_utg);
    check("upd_taken", upd_taken, m_utk);
    check("branch_count", branch_count, 64'(f_sat(m_bc, 32'h7FFF_FFFF)));
    check("mispredict_count", mispredict_count, 64'(f_sat(m_mc, 32'h7FFF_FFFF)));
    check("small_branch_count", s_branch_count, 64'(f_sat(m_bc, 15)));
    check("small_mispredict_count", s_mispredict_count, 64'(f_sat(m_mc, 15)));
  endtask

  // advance model with the inputs that the coming edge samples, then clock
  task automatic step();
    bit res, mp;
    logic [31:0] nxt;
    if (reset) begin
      m_in_flush = 0; m_rv = 0; m_rpc = 0; m_uv = 0; m_upc = 0; m_utg = 0; m_utk = 0;
      m_bc = 0; m_mc = 0;
    end else begin
      res = f_resolves();
      nxt = f_next_pc();
      mp  = res && (nxt != ex_predicted_pc);
      m_rv = mp;
      if (mp) m_rpc = nxt;
      m_uv = res;
      if (res) begin
        m_upc = ex_pc; m_utg = nxt; m_utk = is_jal | is_jalr | (is_branch & bcond);
      end
      if (res) m_bc++;
      if (mp) m_mc++;
      m_in_flush = mp;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit br, input bit jal, input bit jalr, input bit bc,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                       input logic [31:0] pred);
    ex_valid = v; is_branch = br; is_jal = jal; is_jalr = jalr; bcond = bc;
    ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; ex_predicted_pc = pred; is_stall = 0;
  endtask

  task automatic bubble();
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h4);
  endtask

  task automatic do_reset();
    reset = 1; bubble();
    step(); chk(); step();
    reset = 0;
  endtask

  initial begin
    reset = 1; bubble();
    step();
    chk();
    check("rst_redirect_valid", redirect_valid, 0);
    check("rst_branch_count", branch_count, 0);
    check("rst_upd_pc", upd_pc, 0);
    step();
    reset = 0;

    // 1: BEQ taken, predicted not-taken
    drive(1, 1, 0, 0, 1, 32'h40, 32'h10, 32'h0, 32'h44);
    chk();
    check("t1_mispredict", mispredict, 1);
    check("t1_flush", flush_if_id, 1);
    check("t1_actual", actual_pc, 32'h50);
    step();
    bubble(); chk();
    check("t1_flush_T1", flush_id_ex, 1);
    check("t1_redirect_valid", redirect_valid, 1);
    check("t1_redirect_pc", redirect_pc, 32'h50);
    check("t1_upd_valid", upd_valid, 1);
    check("t1_upd_taken", upd_taken, 1);
    check("t1_upd_target", upd_target, 32'h50);
    check("t1_counts", {branch_count, mispredict_count}, {32'd1, 32'd1});
    step();
    chk();
    check("t1_pulse_end", {redirect_valid, upd_valid, flush_if_id}, 0);
    check("t1_redirect_hold", redirect_pc, 32'h50);
    step();

    // 2: BNE not taken, correctly predicted
    do_reset();
    drive(1, 1, 0, 0, 0, 32'h80, 32'h20, 32'h0, 32'h84);
    chk();
    check("t2_mispredict", mispredict, 0);
    step();
    bubble(); chk();
    check("t2_flush", flush_if_id, 0);
    check("t2_redirect_valid", redirect_valid, 0);
    check("t2_upd", {upd_valid, upd_taken}, 2'b10);
    check("t2_upd_target", upd_target, 32'h84);
    check("t2_counts", {branch_count, mispredict_count}, {32'd1, 32'd0});
    step();

    // 3: JALR clears bit 0
    drive(1, 0, 0, 1, 0, 32'h100, 32'h4, 32'h1003, 32'h2000);
    chk();
    check("t3_actual", actual_pc, 32'h1006);
    step();
    bubble(); chk();
    check("t3_redirect_pc", redirect_pc, 32'h1006);
    step();
    chk(); step();

    // sequential PC wraps at 2^32
    drive(1, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h40, 32'h0, 32'h0);
    chk();
    check("wrap_actual", actual_pc, 32'h0);
    check("wrap_mispredict", mispredict, 0);
    step();
    bubble(); chk(); step();

    // 4: stalled branch resolves once
    do_reset();
    drive(1, 1, 0, 0, 1, 32'h200, 32'h8, 32'h0, 32'h208);
    is_stall = 1;
    for (int i = 0; i < 3; i++) begin
      chk();
      if (i > 0) check("t4_no_upd_stall", upd_valid, 0);
      step();
    end
    is_stall = 0;
    chk();
    check("t4_no_upd_yet", upd_valid, 0);
    step();
    bubble(); chk();
    check("t4_upd_once", upd_valid, 1);
    check("t4_bcount", branch_count, 1);
    step();
    chk();
    check("t4_upd_pulse", upd_valid, 0);
    step();

    // 5a: wrong-path JAL during FLUSH ignored
    do_reset();
    drive(1, 0, 1, 0, 0, 32'h300, 32'h40, 32'h0, 32'h304);
    chk();
    check("t5_mispredict", mispredict, 1);
    step();
    drive(1, 0, 1, 0, 0, 32'h340, 32'h100, 32'h0, 32'h344);
    chk();
    check("t5_no_second_mp", mispredict, 0);
    check("t5_flush_T1", flush_if_id, 1);
    step();
    bubble(); chk();
    check("t5_counts", {branch_count, mispredict_count}, {32'd1, 32'd1});
    check("t5_no_upd", {upd_valid, redirect_valid}, 0);
    step();

    // 5b: reset during FLUSH
    drive(1, 0, 1, 0, 0, 32'h300, 32'h40, 32'h0, 32'h304);
    chk(); step();
    reset = 1;
    drive(1, 0, 1, 0, 0, 32'h340, 32'h100, 32'h0, 32'h344);
    chk();
    check("t5b_flush_rst", {flush_if_id, flush_id_ex, mispredict}, 0);
    step();
    reset = 0;
    drive(1, 1, 0, 0, 1, 32'h500, 32'h20, 32'h0, 32'h504);
    chk();
    check("t5b_regs_zero", {redirect_valid, redirect_pc, upd_valid, upd_pc, upd_target, upd_taken}, 0);
    check("t5b_counts_zero", {branch_count, mispredict_count}, 0);
    check("t5b_idle_resolves", mispredict, 1);
    step();
    bubble(); chk(); step();

    // 6: 17 mispredicts -> 4-bit counters saturate
    do_reset();
    for (int k = 0; k < 17; k++) begin
      drive(1, 1, 0, 0, 1, 32'h1000 + 32'(k * 16), 32'h80, 32'h0, 32'h1004 + 32'(k * 16));
      chk(); step();
      bubble(); chk(); step();
      chk(); step();
    end
    chk();
    check("t6_small_counts", {s_branch_count, s_mispredict_count}, {4'd15, 4'd15});
    check("t6_wide_counts", {branch_count, mispredict_count}, {32'd17, 32'd17});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
